sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter HADDR_WIDTH, default 24, meaning host word-address width (bank+row+col).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 4, meaning max cycles to wait for mem_busy rise before reissue.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports p0_req / p1_req  input  1  request, held high until ack.
REQ-006 SHALL have ports p0_we / p1_we  input  1  1 = write, 0 = read; stable while req high.
REQ-007 SHALL have ports p0_addr / p1_addr  input  HADDR_WIDTH  word address; stable while req high.
REQ-008 SHALL have ports p0_wdata / p1_wdata  input  16  write data; stable while req high.
REQ-009 SHALL have ports p0_rdata / p1_rdata  output  16  registered read data per port.
REQ-010 SHALL have ports p0_ack / p1_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports mem_wr_addr, mem_rd_addr  output  HADDR_WIDTH  both driven from one registered address.
REQ-012 SHALL have port mem_wr_data  output  16  registered write data.
REQ-013 SHALL have ports mem_wr_enable, mem_rd_enable  output  1  controller command strobes.
REQ-014 SHALL have ports mem_rd_data  input  16, mem_rd_ready  input  1, mem_busy  input  1  from SDRAM controller.
REQ-015 SHALL have port grant  output  1  index of port owning the current/last transaction.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
REQ-017 IDLE: no req -> stay; else select port, latch addr/wdata/we into registers, set grant, -> ISSUE.
REQ-018 Selection SHALL be round-robin: single requester wins; both requesting -> port != last grant.
REQ-019 ISSUE: if mem_busy=1 stay, strobes low; else assert exactly one of mem_rd_enable/mem_wr_enable (per latched we) for one cycle, clear timeout counter, -> WAIT_BUSY.
REQ-020 WAIT_BUSY: mem_busy=1 -> WAIT_DONE; else count; count reaching BUSY_TIMEOUT -> ISSUE (reissue, same latched command; covers controller in refresh ignoring strobe).
REQ-021 WAIT_DONE, read: on mem_rd_ready=1 capture mem_rd_data into granted port rdata, -> DONE.
REQ-022 WAIT_DONE, write: on mem_busy=0 -> DONE.
REQ-023 DONE: assert granted port ack for exactly one cycle, update last grant, -> IDLE.
REQ-024 Requester SHALL drop req at the edge ending its ack cycle; arbiter samples req only in IDLE, so no double issue.
REQ-025 Non-granted port rdata SHALL hold its value; rdata SHALL change only in REQ-021.
REQ-026 mem_rd_enable and mem_wr_enable SHALL never be high simultaneously, nor outside ISSUE.
REQ-027 Req changes outside IDLE SHALL be ignored; a waiting port is served next (round-robin guarantees no starvation).
REQ-028 Latency (controller idle, no refresh): strobe 1 cycle after req sampled; ack 1 cycle after rd_ready (read) or busy fall (write).

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, all strobes/acks 0, rdata 0, address/wdata registers 0, grant 0, last grant = 1 (port 0 wins first tie).
REQ-030 Reset mid-transaction SHALL abort without ack; after release, arbitration restarts from IDLE.

Verification
REQ-031 p0 write addr 0x000123 data 0xBEEF, idle model -> one mem_wr_enable pulse with mem_wr_addr 0x000123, mem_wr_data 0xBEEF; p0_ack after busy falls.
REQ-032 p1 read addr 0x3FFFFF, model returns 0x1234 -> p1_rdata=0x1234 on p1_ack cycle; p0_rdata unchanged.
REQ-033 p0 and p1 both req from reset, repeated 4 times -> grant order 0,1,0,1; exactly one ack per transaction.
REQ-034 Model ignores first strobe (refresh, busy low 10 cycles) -> strobe reissued after BUSY_TIMEOUT=4 cycles, single ack.
REQ-035 rst_n low during WAIT_DONE -> no ack, all outputs 0 immediately; next request completes normally.
REQ-036 Bench SHALL assert REQ-026 and single-cycle ack every cycle.

Source files
------------

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module      : sdram_arbiter
// Description : Two-port round-robin arbiter in front of a single-command
//               SDRAM controller, with strobe reissue on busy timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sdram_arbiter #(
    parameter int HADDR_WIDTH  = 24,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [HADDR_WIDTH-1:0] p0_addr,
    input  logic [15:0]            p0_wdata,
    output logic [15:0]            p0_rdata,
    output logic                   p0_ack,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [HADDR_WIDTH-1:0] p1_addr,
    input  logic [15:0]            p1_wdata,
    output logic [15:0]            p1_rdata,
    output logic                   p1_ack,
    output logic [HADDR_WIDTH-1:0] mem_wr_addr,
    output logic [HADDR_WIDTH-1:0] mem_rd_addr,
    output logic [15:0]            mem_wr_data,
    output logic                   mem_wr_enable,
    output logic                   mem_rd_enable,
    input  logic [15:0]            mem_rd_data,
    input  logic                   mem_rd_ready,
    input  logic                   mem_busy,
    output logic                   grant
);

    localparam int              CNT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   grant_q;
    logic                   last_grant_q;
    logic                   we_q;
    logic [HADDR_WIDTH-1:0] addr_q;
    logic [15:0]            wdata_q;
    logic                   rd_en_q;
    logic                   wr_en_q;
    logic                   ack0_q;
    logic                   ack1_q;
    logic [15:0]            rdata0_q;
    logic [15:0]            rdata1_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   sel_d;
    logic                   we_d;
    logic [HADDR_WIDTH-1:0] addr_d;
    logic [15:0]            wdata_d;

    // On a tie the port that did not own the last transaction wins.
    always_comb begin
        sel_d   = (p0_req && p1_req) ? ~last_grant_q : p1_req;
        we_d    = sel_d ? p1_we    : p0_we;
        addr_d  = sel_d ? p1_addr  : p0_addr;
        wdata_d = sel_d ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            cnt_q        <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        grant_q <= sel_d;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_busy) begin
                        wr_en_q <= we_q;
                        rd_en_q <= ~we_q;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_BUSY;
                    end
                end
                // A controller busy with refresh may drop the strobe; retry it.
                ST_WAIT_BUSY: begin
                    if (mem_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (we_q) begin
                        if (!mem_busy) begin
                            ack0_q  <= ~grant_q;
                            ack1_q  <= grant_q;
                            state_q <= ST_DONE;
                        end
                    end else if (mem_rd_ready) begin
                        if (grant_q) begin
                            rdata1_q <= mem_rd_data;
                        end else begin
                            rdata0_q <= mem_rd_data;
                        end
                        ack0_q  <= ~grant_q;
                        ack1_q  <= grant_q;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0_rdata      = rdata0_q;
    assign p1_rdata      = rdata1_q;
    assign p0_ack        = ack0_q;
    assign p1_ack        = ack1_q;
    assign mem_wr_addr   = addr_q;
    assign mem_rd_addr   = addr_q;
    assign mem_wr_data   = wdata_q;
    assign mem_wr_enable = wr_en_q;
    assign mem_rd_enable = rd_en_q;
    assign grant         = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Scoreboard bench for sdram_arbiter with a small SDRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sdram_arbiter;

    localparam int AW  = 24;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [15:0]   p0_wdata = '0, p1_wdata = '0;
    logic [15:0]   p0_rdata, p1_rdata;
    logic          p0_ack, p1_ack;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [15:0]   mem_wr_data;
    logic          mem_wr_enable, mem_rd_enable;
    logic [15:0]   mem_rd_data = '0;
    logic          mem_rd_ready = 1'b0;
    logic          mem_busy = 1'b0;
    logic          grant;

    sdram_arbiter #(.HADDR_WIDTH(AW), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
        .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready), .mem_busy(mem_busy),
        .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [15:0]   rdata;
        int            nstb;
        bit            chk_lat;
        int            req_cyc;
    } txn_t;

    txn_t exp0[$];
    txn_t exp1[$];
    int   exp_grant[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   m_lat = 3;
    int   ign_req = 0;
    int   ign_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic violation(input string name, input logic [31:0] act);
        n_fail++;
        $display("FAIL %s: observed 0x%0h (cycle %0d)", name, act, cyc);
    endtask

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Controller model: reads return addr[15:0] ^ 16'hEDCB after m_lat busy cycles.
    task automatic model_proc();
        int            cnt = 0;
        logic          rd = 1'b0;
        logic [AW-1:0] a = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_busy = 1'b0; mem_rd_ready = 1'b0; mem_rd_data = '0; cnt = 0;
            end else begin
                mem_rd_ready = 1'b0;
                if (mem_rd_enable || mem_wr_enable) begin
                    if (ign_req != ign_done) begin
                        ign_done++;
                    end else begin
                        mem_busy = 1'b1; cnt = m_lat; rd = mem_rd_enable; a = mem_rd_addr;
                    end
                end else if (mem_busy) begin
                    if (cnt > 0) begin
                        cnt--;
                    end else begin
                        mem_busy = 1'b0;
                        done_cyc = cyc;
                        if (rd) begin
                            mem_rd_ready = 1'b1;
                            mem_rd_data  = a[15:0] ^ 16'hEDCB;
                        end
                    end
                end
            end
        end
    endtask

    task automatic monitor_proc();
        logic [15:0] seen[2];
        logic        prev_ack[2];
        logic        ack[2];
        logic [15:0] rd[2];
        logic        rd_ack[2];
        int          stb_cnt = 0;
        int          last_stb = 0;
        int          p;
        txn_t        e;
        seen[0] = '0; seen[1] = '0; prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen[0] = '0; seen[1] = '0; prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
                stb_cnt = 0;
                continue;
            end
            ack[0] = p0_ack; ack[1] = p1_ack; rd[0] = p0_rdata; rd[1] = p1_rdata;
            rd_ack[0] = 1'b0; rd_ack[1] = 1'b0;
            if (mem_rd_enable && mem_wr_enable) violation("strobes_both_high", 32'h3);
            if (ack[0] && ack[1]) violation("acks_both_high", 32'h3);
            if (mem_rd_enable || mem_wr_enable) begin
                p = int'(grant);
                if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
                    violation("unexpected_strobe", mem_rd_addr);
                end else begin
                    e = (p == 0) ? exp0[0] : exp1[0];
                    chk("strobe_is_write", mem_wr_enable, e.we);
                    chk("mem_wr_addr", mem_wr_addr, e.addr);
                    chk("mem_rd_addr", mem_rd_addr, e.addr);
                    if (e.we) chk("mem_wr_data", mem_wr_data, e.wdata);
                    if (stb_cnt == 0) begin
                        if (e.chk_lat) chk("strobe_latency", cyc - e.req_cyc, 2);
                    end else begin
                        // TMO idle cycles in WAIT_BUSY, then one ISSUE cycle.
                        chk("reissue_gap", cyc - last_stb, TMO + 1);
                    end
                    last_stb = cyc;
                    stb_cnt++;
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (ack[q] && prev_ack[q]) violation("ack_longer_than_one_cycle", q);
                if (ack[q] && !prev_ack[q]) begin
                    if ((q == 0 && exp0.size() == 0) || (q == 1 && exp1.size() == 0)) begin
                        violation("unexpected_ack", q);
                    end else begin
                        e = (q == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk("ack_grant", grant, q);
                        if (exp_grant.size() == 0) violation("grant_order_extra", q);
                        else chk("grant_order", q, exp_grant.pop_front());
                        chk("strobe_count", stb_cnt, e.nstb);
                        chk("ack_latency", cyc - done_cyc, 1);
                        if (!e.we) begin
                            chk("rdata", rd[q], e.rdata);
                            rd_ack[q] = 1'b1;
                        end
                        stb_cnt = 0;
                    end
                end
                if (rd[q] !== seen[q] && !rd_ack[q]) violation("rdata_changed_without_read", rd[q]);
                seen[q] = rd[q];
                prev_ack[q] = ack[q];
            end
        end
    endtask

    task automatic do_req(input int p, input logic we, input logic [AW-1:0] addr,
                          input logic [15:0] wd, input logic [15:0] rx, input int nstb,
                          input bit lat);
        txn_t e;
        bit   got = 1'b0;
        @(negedge clk);
        e.we = we; e.addr = addr; e.wdata = wd; e.rdata = rx;
        e.nstb = nstb; e.chk_lat = lat; e.req_cyc = cyc;
        if (p == 0) begin
            exp0.push_back(e); p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            exp1.push_back(e); p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? p0_ack : p1_ack) got = 1'b1;
        end
        @(posedge clk);
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL ack_timeout: port %0d got no ack, expected one within 300 cycles", p);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_p0_ack"}, p0_ack, 0);
        chk({tag, "_p1_ack"}, p1_ack, 0);
        chk({tag, "_wr_en"}, mem_wr_enable, 0);
        chk({tag, "_rd_en"}, mem_rd_enable, 0);
        chk({tag, "_p0_rdata"}, p0_rdata, 0);
        chk({tag, "_p1_rdata"}, p1_rdata, 0);
        chk({tag, "_wr_addr"}, mem_wr_addr, 0);
        chk({tag, "_rd_addr"}, mem_rd_addr, 0);
        chk({tag, "_wr_data"}, mem_wr_data, 0);
        chk({tag, "_grant"}, grant, 0);
    endtask

    initial begin
        txn_t ab;
        fork
            cycle_counter();
            model_proc();
            monitor_proc();
            begin
                #200000;
                $display("FAIL watchdog: simulation still running at 200us, expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 rst_n = 1'b1;

        // p0 write, then p1 read of the top address
        exp_grant.push_back(0);
        do_req(0, 1'b1, 24'h000123, 16'hBEEF, 16'h0000, 1, 1'b1);
        exp_grant.push_back(1);
        do_req(1, 1'b0, 24'h3FFFFF, 16'h0000, 16'h1234, 1, 1'b1);

        // Both ports contend twice each: strict alternation from port 0
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            begin
                do_req(0, 1'b1, 24'h000100, 16'h1111, 16'h0000, 1, 1'b0);
                do_req(0, 1'b1, 24'h000200, 16'h2222, 16'h0000, 1, 1'b0);
            end
            begin
                do_req(1, 1'b0, 24'h000010, 16'h0000, 16'hEDDB, 1, 1'b0);
                do_req(1, 1'b0, 24'h00ABCD, 16'h0000, 16'h4606, 1, 1'b0);
            end
        join

        // Controller drops the first strobe (refresh); arbiter must reissue
        ign_req++;
        exp_grant.push_back(1);
        do_req(1, 1'b1, 24'h055555, 16'h5A5A, 16'h0000, 2, 1'b1);

        // Reset while a p0 read is waiting for data
        m_lat = 8;
        @(negedge clk);
        ab.we = 1'b0; ab.addr = 24'h000042; ab.wdata = '0; ab.rdata = '0;
        ab.nstb = 1; ab.chk_lat = 1'b1; ab.req_cyc = cyc;
        exp0.push_back(ab);
        p0_we = 1'b0; p0_addr = 24'h000042; p0_req = 1'b1;
        for (int i = 0; i < 50 && !mem_busy; i++) @(negedge clk);
        chk("abort_busy_seen", mem_busy, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        p0_req = 1'b0;
        exp0.delete();
        m_lat = 3;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // After reset: port 0 regains tie priority, single requests complete
        exp_grant.push_back(1);
        do_req(1, 1'b0, 24'h000000, 16'h0000, 16'hEDCB, 1, 1'b1);
        exp_grant.push_back(0);
        do_req(0, 1'b0, 24'h000042, 16'h0000, 16'hED89, 1, 1'b1);

        repeat (5) @(negedge clk);
        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);
        chk("grant_order_drained", exp_grant.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
